// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and width helpers
// for the PWM fade sequencer and its tick generator.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  localparam int PREC_DEF  = 8;
  localparam int CMP_W_DEF = PREC_DEF + 1;

  // One guard bit so level/step sums never wrap.
  function automatic int cmp_w(input int prec);
    return prec + 1;
  endfunction

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// pwm_fade_ctrl_if: control/status bundle between
// a control source (master) and the fade sequencer.
interface pwm_fade_ctrl_if
  import pwm_pkg::*;
#(
  parameter int PRECISION = PREC_DEF
);

  logic                 start;
  logic                 stop;
  logic                 loop;
  logic [PRECISION-1:0] duty_min;
  logic [PRECISION-1:0] duty_max;
  logic [PRECISION-1:0] step;
  logic [PRECISION-1:0] compare;
  logic                 busy;
  logic [2:0]           phase;
  logic                 cycle_done;

  modport master (
    output start, stop, loop,
    output duty_min, duty_max, step,
    input  compare, busy, phase, cycle_done
  );

  modport slave (
    input  start, stop, loop,
    input  duty_min, duty_max, step,
    output compare, busy, phase, cycle_done
  );

endinterface

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: free-running divider that pulses
// tick once every DIV clocks while enabled.
module pwm_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Divider count, restarted on clear, wraps on tick.
  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable)
      cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramp/hold fade sequencer driving a PWM compare.
// Define PWM_FADE_GAMMA_EN for squared (gamma) compare output.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int CLK_NUM    = 27000000,
  parameter int PRECISION  = PREC_DEF,
  parameter int STEP_HZ    = 1000,
  parameter int TICK_DIV   = CLK_NUM / STEP_HZ,
  parameter int HOLD_TICKS = 256
) (
  input logic           clk,
  input logic           rst,
  pwm_fade_ctrl_if.slave bus
);

  localparam int W  = cmp_w(PRECISION);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_TICKS - 1);

  typedef logic [PRECISION-1:0] duty_t;

  state_t        state_q, state_d;
  duty_t         level_q, level_d;
  duty_t         min_q, min_d;
  duty_t         max_q, max_d;
  duty_t         step_q, step_d;
  logic          loop_q, loop_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          done_q, done_d;
  logic          tick, start_acc, stop_acc;
  logic [W-1:0]  up_sum, dn_lim;

  assign start_acc = (state_q == IDLE) && bus.start && !bus.stop;
  assign stop_acc  = (state_q != IDLE) && bus.stop;
  assign up_sum    = {1'b0, level_q} + {1'b0, step_q};
  assign dn_lim    = {1'b0, min_q} + {1'b0, step_q};

  pwm_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (state_q != IDLE),
    .clear  (start_acc),
    .tick   (tick)
  );

  // Sequencer state and profile registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      step_q  <= '0;
      loop_q  <= 1'b0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      min_q   <= min_d;
      max_q   <= max_d;
      step_q  <= step_d;
      loop_q  <= loop_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  // Next state: stop beats tick and start.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    min_d   = min_q;
    max_d   = max_q;
    step_d  = step_q;
    loop_d  = loop_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (stop_acc) begin
      state_d = IDLE;
      level_d = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start_acc) begin
          min_d   = bus.duty_min;
          max_d   = (bus.duty_max < bus.duty_min) ?
                    bus.duty_min : bus.duty_max;
          step_d  = (bus.step == '0) ? duty_t'(1) : bus.step;
          loop_d  = bus.loop;
          level_d = bus.duty_min;
          hold_d  = '0;
          state_d = RAMP_UP;
        end
        RAMP_UP: if (tick) begin
          if (up_sum >= {1'b0, max_q}) begin
            level_d = max_q;
            hold_d  = '0;
            state_d = HOLD_HIGH;
          end else begin
            level_d = up_sum[PRECISION-1:0];
          end
        end
        HOLD_HIGH: if (tick) begin
          if (hold_q == HLAST) begin
            hold_d  = '0;
            state_d = RAMP_DOWN;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        RAMP_DOWN: if (tick) begin
          if ({1'b0, level_q} <= dn_lim) begin
            level_d = min_q;
            hold_d  = '0;
            state_d = HOLD_LOW;
          end else begin
            level_d = level_q - step_q;
          end
        end
        HOLD_LOW: if (tick) begin
          if (hold_q == HLAST) begin
            hold_d  = '0;
            done_d  = 1'b1;
            state_d = loop_q ? RAMP_UP : IDLE;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PWM_FADE_GAMMA_EN
  logic [2*PRECISION-1:0] sq;
  duty_t                  cmp_q;

  assign sq = {{PRECISION{1'b0}}, level_q} *
              {{PRECISION{1'b0}}, level_q};

  // Squared level, one clock behind; stop zeroes it at once.
  always_ff @(posedge clk) begin
    if (rst || stop_acc)
      cmp_q <= '0;
    else
      cmp_q <= sq[2*PRECISION-1:PRECISION];
  end

  assign bus.compare = cmp_q;
`else
  assign bus.compare = level_q;
`endif

  assign bus.busy       = (state_q != IDLE);
  assign bus.phase      = state_q;
  assign bus.cycle_done = done_q;

endmodule
